bg_tile_renderer: RTL

Read side of the background tile map that the game engine writes through `bg_ram_addr`, `bg_ram_data` and `bg_wea`. Each pixel clock the block:

- converts the VGA scan position plus the horizontal scroll offset into a tile-map address;
- reads the tile attribute word and turns it into a tileset-ROM pixel address, applying X/Y flip;
- outputs a 12-bit RGB pixel, handling transparency and disabled tiles.

It also has a one-outstanding request/acknowledge probe port. Game logic uses it to read any tile attribute during slots the renderer does not need.

---
 rtl/bg_tile_renderer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bg_tile_renderer.sv
// Background tile renderer: scan position -> tile-map attribute -> tileset ROM -> RGB444,
// with a probe port that borrows tile-map read slots the renderer leaves idle.
module bg_tile_renderer #(
    parameter int unsigned TILE_COLS   = 40,
    parameter int unsigned TILE_ROWS   = 30,
    parameter logic [11:0] BG_COLOR    = 12'h6AF,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic [13:0] rom_addr,
    input  logic [11:0] rom_rdata,
    output logic [11:0] rgb,
    output logic        rgb_valid,
    input  logic        probe_req,
    input  logic [5:0]  probe_col,
    input  logic [4:0]  probe_row,
    output logic        probe_ack,
    output logic [8:0]  probe_data
);
    localparam logic [6:0]  COLS7  = 7'(TILE_COLS);
    localparam logic [15:0] COLS16 = 16'(TILE_COLS);
    localparam logic [5:0]  ROWS6  = 6'(TILE_ROWS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} probe_state_t;
    probe_state_t state, state_next;

    logic [10:0] xs;
    logic [6:0]  tcol_raw;
    logic [6:0]  tcol;
    logic [5:0]  trow;
    logic [15:0] render_addr;
    logic [15:0] probe_addr;
    logic        slot_in;
    logic        probe_in_range;
    logic        grant;
    logic        capture;
    logic        wait_phase;
    logic        probe_oor;

    logic [3:0]  px_a, py_a, px_b, py_b, px_f, py_f;
    logic        slot_a, pix_a, slot_b, pix_b, slot_c, pix_c, en_c;
    logic        unused_attr_bits;

    // Stage A address generation
    always_comb begin
        xs          = {1'b0, x} + {7'b0, bg_x_offset};
        tcol_raw    = xs[10:4];
        tcol        = (tcol_raw >= COLS7) ? (tcol_raw - COLS7) : tcol_raw;
        trow        = y[9:4];
        render_addr = {10'b0, trow} * COLS16 + {9'b0, tcol};
        slot_in     = pix_en & video_on;
    end

    always_comb begin
        probe_addr     = {11'b0, probe_row} * COLS16 + {10'b0, probe_col};
        probe_in_range = ({1'b0, probe_col} < COLS7) && ({1'b0, probe_row} < ROWS6);
    end

    // Probe FSM next-state and strobes
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (probe_req) state_next = ISSUE;
            end
            ISSUE: begin
                if (!slot_in) begin
                    grant      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_phase) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // WAIT spans two cycles: one for the RAM to sample the address, one for data to return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_phase <= 1'b0;
            probe_oor  <= 1'b0;
            probe_ack  <= 1'b0;
            probe_data <= '0;
        end else begin
            state      <= state_next;
            wait_phase <= (state == WAIT) && !wait_phase;
            probe_ack  <= capture;
            if (grant) probe_oor <= !probe_in_range;
            if (capture) probe_data <= probe_oor ? '0 : ram_rdata[8:0];
        end
    end

    // Stage A registers; an out-of-range probe grant leaves the RAM address untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr <= '0;
            px_a     <= '0;
            py_a     <= '0;
            slot_a   <= 1'b0;
            pix_a    <= 1'b0;
        end else begin
            if (grant) begin
                if (probe_in_range) ram_addr <= probe_addr;
            end else begin
                ram_addr <= render_addr;
            end
            px_a   <= xs[3:0];
            py_a   <= y[3:0];
            slot_a <= slot_in;
            pix_a  <= pix_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_b   <= '0;
            py_b   <= '0;
            slot_b <= 1'b0;
            pix_b  <= 1'b0;
        end else begin
            px_b   <= px_a;
            py_b   <= py_a;
            slot_b <= slot_a;
            pix_b  <= pix_a;
        end
    end

    // Stage B: attribute word arrives this cycle; ROM samples the address at the next edge
    always_comb begin
        px_f             = ram_rdata[6] ? (4'd15 - px_b) : px_b;
        py_f             = ram_rdata[7] ? (4'd15 - py_b) : py_b;
        rom_addr         = slot_b ? {ram_rdata[5:3], py_f, ram_rdata[2:0], px_f} : '0;
        unused_attr_bits = ^ram_rdata[31:9];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_c <= 1'b0;
            pix_c  <= 1'b0;
            en_c   <= 1'b0;
        end else begin
            slot_c <= slot_b;
            pix_c  <= pix_b;
            en_c   <= ram_rdata[8];
        end
    end

    // Stage C colour select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            if (!slot_c) begin
                rgb <= '0;
            end else if (!en_c || (rom_rdata == TRANSPARENT)) begin
                rgb <= BG_COLOR;
            end else begin
                rgb <= rom_rdata;
            end
            rgb_valid <= pix_c;
        end
    end

endmodule
